fft_frame_sequencer: RTL

Frame-level controller for the FFT core. On a software `start` it issues one runtime configuration beat on the FFT config channel, then gates exactly one frame of N input samples into the FFT data channel, inserting `tlast` itself, and counts N output samples before reporting completion. It sits between the register bank and the FFT core, replacing ad-hoc config commits with a sequenced config → data → drain flow.

---
 rtl/fft_frame_sequencer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/fft_frame_sequencer.sv
// Frame sequencer for the FFT core: one config beat, one N-sample frame with tlast, then an N-beat output drain.
// Optional FFT_SEQ_CONTINUOUS_EN adds a `continuous` input that chains frames without reconfiguring.
module fft_frame_sequencer #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned LOG2_NFFT_MAX = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4:0]            nfft_log2,
  input  logic [7:0]            scale_sch,
  input  logic                  forward,
`ifdef FFT_SEQ_CONTINUOUS_EN
  input  logic                  continuous,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  err_tlast,
  output logic [15:0]           frame_count,
  output logic                  cfg_tvalid,
  input  logic                  cfg_tready,
  output logic [23:0]           cfg_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tlast,
  input  logic                  out_tvalid,
  input  logic                  out_tready,
  input  logic                  out_tlast
);

  localparam int unsigned CNT_W = LOG2_NFFT_MAX;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CONFIG = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [4:0]       nlog_q, nlog_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             cfg_valid_q, cfg_valid_d;
  logic [23:0]      cfg_data_q, cfg_data_d;

  logic [4:0]       nlog_clamped;
  logic [CNT_W-1:0] last_idx;
  logic             in_stream;
  logic             in_hs;
  logic             out_hs;
  logic             in_last;
  logic             out_last;
  logic             cont;

`ifdef FFT_SEQ_CONTINUOUS_EN
  assign cont = continuous;
`else
  assign cont = 1'b0;
`endif

  // Clamp requested size into the supported range.
  always_comb begin
    nlog_clamped = nfft_log2;
    if (nfft_log2 < 5'd3) begin
      nlog_clamped = 5'd3;
    end else if (nfft_log2 > 5'(LOG2_NFFT_MAX)) begin
      nlog_clamped = 5'(LOG2_NFFT_MAX);
    end
  end

  // N-1 as a low-bit mask; the full-width case yields all ones without overflow.
  assign last_idx = ~({CNT_W{1'b1}} << nlog_q);

  assign in_stream = (state_q == S_STREAM);
  assign m_tvalid  = in_stream & s_tvalid;
  assign s_tready  = in_stream & m_tready;
  assign m_tdata   = s_tdata;
  assign in_last   = (in_cnt_q == last_idx);
  assign m_tlast   = in_stream & in_last;
  assign in_hs     = m_tvalid & m_tready;
  assign out_hs    = out_tvalid & out_tready;
  assign out_last  = (out_cnt_q == last_idx);

  always_comb begin
    state_d     = state_q;
    nlog_d      = nlog_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    frame_cnt_d = frame_cnt_q;
    cfg_valid_d = cfg_valid_q;
    cfg_data_d  = cfg_data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          nlog_d      = nlog_clamped;
          cfg_data_d  = {7'b0, scale_sch, forward, 3'b0, nlog_clamped};
          cfg_valid_d = 1'b1;
          in_cnt_d    = '0;
          out_cnt_d   = '0;
          busy_d      = 1'b1;
          state_d     = S_CONFIG;
        end
      end
      S_CONFIG: begin
        if (cfg_tready) begin
          cfg_valid_d = 1'b0;
          state_d     = S_STREAM;
        end
      end
      S_STREAM: begin
        if (in_hs) begin
          in_cnt_d = in_cnt_q + CNT_W'(1);
          if (in_last) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (out_hs) begin
          out_cnt_d = out_cnt_q + CNT_W'(1);
          err_d     = out_tlast ^ out_last;
          if (out_last) begin
            done_d      = 1'b1;
            frame_cnt_d = frame_cnt_q + 16'd1;
            in_cnt_d    = '0;
            out_cnt_d   = '0;
            if (cont) begin
              state_d = S_STREAM;
            end else begin
              busy_d  = 1'b0;
              state_d = S_IDLE;
            end
          end
        end
      end
      default: begin
        busy_d      = 1'b0;
        cfg_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      nlog_q      <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
      cfg_valid_q <= 1'b0;
      cfg_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      nlog_q      <= nlog_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
      cfg_valid_q <= cfg_valid_d;
      cfg_data_q  <= cfg_data_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign err_tlast   = err_q;
  assign frame_count = frame_cnt_q;
  assign cfg_tvalid  = cfg_valid_q;
  assign cfg_tdata   = cfg_data_q;

endmodule
